// File: rtl/raizing_sdram_pkg.sv
// Shared SDRAM bank definitions for the raizing ROM slots.
// Contents: bank address/data widths, slot FSM state encoding, and the
// client-address to bank-word-address mapping.
package raizing_sdram_pkg;

  localparam int unsigned SDRAM_AW = 22;
  localparam int unsigned SDRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Scale a client address (in client-data-width units) to a 16-bit bank
  // word address and add the region base; the sum wraps modulo 2^22.
  function automatic logic [SDRAM_AW-1:0] word_addr(
    input int unsigned           dw,
    input logic [SDRAM_AW-1:0]   offset,
    input logic [31:0]           addr
  );
    logic [SDRAM_AW-1:0] rel;
    case (dw)
      8:       rel = SDRAM_AW'(addr >> 1);
      32:      rel = SDRAM_AW'(addr << 1);
      default: rel = SDRAM_AW'(addr);
    endcase
    return offset + rel;
  endfunction

endpackage

// File: rtl/raizing_rom_slot.sv
// ROM request slot: turns a client CS/ADDR request into an SDRAM bank read,
// gathers the 1-2 returned words and presents OK/DOUT. A one-entry tag cache
// answers repeated addresses without touching the bank.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   CS, ADDR              client request and address (client-width units)
//   OK, DOUT              data valid for current ADDR, read data (combinational)
//   BA_ADDR, BA_RD        bank word address and read request (registered)
//   BA_ACK                bank accepted the request
//   BA_DST, BA_DOK, BA_RDY first word / word valid / last word strobes
//   DATA_READ             bank read data
module raizing_rom_slot
  import raizing_sdram_pkg::*;
#(
  parameter int unsigned         AW     = 22,
  parameter int unsigned         DW     = 16,
  parameter logic [SDRAM_AW-1:0] OFFSET = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CS,
  input  logic [AW-1:0]       ADDR,
  output logic                OK,
  output logic [DW-1:0]       DOUT,
  output logic [SDRAM_AW-1:0] BA_ADDR,
  output logic                BA_RD,
  input  logic                BA_ACK,
  input  logic                BA_DST,
  input  logic                BA_DOK,
  input  logic                BA_RDY,
  input  logic [SDRAM_DW-1:0] DATA_READ
);

  localparam int unsigned DDW = (DW > 16) ? DW : 16;
  // Byte clients share one cached word between both byte addresses.
  localparam logic [AW-1:0] TAG_MASK = (DW == 8) ? ~AW'(1) : '1;

  if (DW != 8 && DW != 16 && DW != 32) begin : g_bad_dw
    $error("raizing_rom_slot: DW must be 8, 16 or 32");
  end

  state_e                state_q, state_d;
  logic [AW-1:0]         pend_q, pend_d;
  logic [AW-1:0]         tag_q, tag_d;
  logic                  v_q, v_d;
  logic [DDW-1:0]        d_q, d_d;
  logic [SDRAM_AW-1:0]   ba_addr_q, ba_addr_d;
  logic                  ba_rd_q, ba_rd_d;
  logic                  got_dst_q, got_dst_d;
  logic                  tag_hit_c;
  logic                  capture_c;

  // Cache hit: valid tag matching the live address.
  assign tag_hit_c = ((tag_q ^ ADDR) & TAG_MASK) == '0;
  assign OK        = CS & v_q & tag_hit_c;
  assign BA_ADDR   = ba_addr_q;
  assign BA_RD     = ba_rd_q;

  if (DW == 8) begin : g_dout8
    assign DOUT = ADDR[0] ? d_q[15:8] : d_q[7:0];
  end else begin : g_dout
    assign DOUT = d_q[DW-1:0];
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (CS && !OK) state_d = REQ;
      REQ:     if (BA_ACK)    state_d = DATA;
      DATA:    if (BA_RDY)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: request issue, word capture, cache fill.
  always_comb begin
    pend_d    = pend_q;
    tag_d     = tag_q;
    v_d       = v_q;
    d_d       = d_q;
    ba_addr_d = ba_addr_q;
    ba_rd_d   = ba_rd_q;
    got_dst_d = got_dst_q;
    // A word arriving together with the ACK is taken as well.
    capture_c = (state_q == DATA) || (state_q == REQ && BA_ACK);

    case (state_q)
      IDLE: begin
        if (CS && !OK) begin
          pend_d    = ADDR;
          ba_addr_d = word_addr(DW, OFFSET, 32'(ADDR));
          ba_rd_d   = 1'b1;
          v_d       = 1'b0;
          got_dst_d = 1'b0;
        end
      end
      REQ: begin
        if (BA_ACK) ba_rd_d = 1'b0;
      end
      DATA: begin
        if (BA_RDY) begin
          tag_d = pend_q;
          v_d   = 1'b1;
        end
      end
      default: ;
    endcase

    if (capture_c) begin
      if (BA_DOK && BA_DST) begin
        d_d[15:0] = DATA_READ;
        got_dst_d = 1'b1;
      end else if (BA_RDY && !got_dst_q) begin
        // Burst ended without a first-word marker: treat it as the low word.
        d_d[15:0] = DATA_READ;
      end else if (BA_DOK && DW == 32) begin
        d_d[DDW-1:DDW-16] = DATA_READ;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_q    <= '0;
      tag_q     <= '0;
      v_q       <= 1'b0;
      d_q       <= '0;
      ba_addr_q <= '0;
      ba_rd_q   <= 1'b0;
      got_dst_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      tag_q     <= tag_d;
      v_q       <= v_d;
      d_q       <= d_d;
      ba_addr_q <= ba_addr_d;
      ba_rd_q   <= ba_rd_d;
      got_dst_q <= got_dst_d;
    end
  end

endmodule

// File: tb/tb_raizing_rom_slot.sv
// Self-checking bench for raizing_rom_slot: three slots (DW=16 at 0x100000,
// DW=32 and DW=8 at 0) share one bank model; only one slot requests at a time.
module tb_raizing_rom_slot;

  logic        clk = 1'b0;
  logic        reset;
  logic        ack, dst, dok, rdy;
  logic [15:0] rdata;

  logic        cs16, cs32, cs8;
  logic [21:0] addr16, addr32, addr8;
  logic        ok16, ok32, ok8;
  logic [15:0] dout16;
  logic [31:0] dout32;
  logic [7:0]  dout8;
  logic [21:0] ba16, ba32, ba8;
  logic        rd16, rd32, rd8;

  int          checks = 0;
  int          errors = 0;
  int          sel = 0;

  logic        s_ok, s_rd;
  logic [31:0] s_dout;
  logic [21:0] s_ba;

  always #5 clk = ~clk;

  raizing_rom_slot #(.AW(22), .DW(16), .OFFSET(22'h100000)) u16 (
    .CLK(clk), .RESET(reset), .CS(cs16), .ADDR(addr16), .OK(ok16), .DOUT(dout16),
    .BA_ADDR(ba16), .BA_RD(rd16), .BA_ACK(ack), .BA_DST(dst), .BA_DOK(dok),
    .BA_RDY(rdy), .DATA_READ(rdata));

  raizing_rom_slot #(.AW(22), .DW(32), .OFFSET(22'h0)) u32 (
    .CLK(clk), .RESET(reset), .CS(cs32), .ADDR(addr32), .OK(ok32), .DOUT(dout32),
    .BA_ADDR(ba32), .BA_RD(rd32), .BA_ACK(ack), .BA_DST(dst), .BA_DOK(dok),
    .BA_RDY(rdy), .DATA_READ(rdata));

  raizing_rom_slot #(.AW(22), .DW(8), .OFFSET(22'h0)) u8 (
    .CLK(clk), .RESET(reset), .CS(cs8), .ADDR(addr8), .OK(ok8), .DOUT(dout8),
    .BA_ADDR(ba8), .BA_RD(rd8), .BA_ACK(ack), .BA_DST(dst), .BA_DOK(dok),
    .BA_RDY(rdy), .DATA_READ(rdata));

  always_comb begin
    case (sel)
      1:       begin s_ok = ok32; s_rd = rd32; s_ba = ba32; s_dout = dout32;      end
      2:       begin s_ok = ok8;  s_rd = rd8;  s_ba = ba8;  s_dout = 32'(dout8);  end
      default: begin s_ok = ok16; s_rd = rd16; s_ba = ba16; s_dout = 32'(dout16); end
    endcase
  end

  typedef struct {
    int          sel;
    logic [21:0] addr;
    logic        hit;
    logic        two;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [21:0] exp_ba;
    logic [31:0] exp_dout;
  } vec_t;

  typedef struct {
    logic [21:0] ba;
    logic [31:0] dout;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int s, input logic [21:0] a);
    sel  = s;
    cs16 = (s == 0); cs32 = (s == 1); cs8 = (s == 2);
    if (s == 0) addr16 = a;
    if (s == 1) addr32 = a;
    if (s == 2) addr8  = a;
  endtask

  // Bounded wait for the selected slot to raise BA_RD.
  task automatic wait_rd(input string name);
    int n = 0;
    while (!s_rd && n < 10) begin
      tick();
      n++;
    end
    chk(name, 32'(s_rd), 32'd1);
  endtask

  // Bank model: ACK after 3 idle cycles, then a 1- or 2-word burst.
  task automatic bank_burst(input string name, input logic two,
                            input logic [15:0] w0, input logic [15:0] w1);
    logic dropped = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!s_rd) dropped = 1'b1;
    end
    chk({name, "_rd_hold"}, 32'(dropped), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk({name, "_rd_after_ack"}, 32'(s_rd), 32'd0);
    dst = 1'b1; dok = 1'b1; rdy = !two; rdata = w0;
    tick();
    dst = 1'b0; dok = 1'b0; rdy = 1'b0;
    if (two) begin
      dok = 1'b1; rdy = 1'b1; rdata = w1;
      tick();
      dok = 1'b0; rdy = 1'b0;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    string nm;
    logic saw_rd = 1'b0;
    nm = $sformatf("vec%0d", idx);
    set_req(v.sel, v.addr);
    sb.push_back('{ba: v.exp_ba, dout: v.exp_dout});
    #1;
    if (v.hit) begin
      chk({nm, "_hit_ok"}, 32'(s_ok), 32'd1);
      e = sb.pop_front();
      chk({nm, "_hit_dout"}, s_dout, e.dout);
      for (int i = 0; i < 3; i++) begin
        tick();
        if (s_rd) saw_rd = 1'b1;
      end
      chk({nm, "_hit_no_rd"}, 32'(saw_rd), 32'd0);
    end else begin
      chk({nm, "_miss_ok"}, 32'(s_ok), 32'd0);
      wait_rd({nm, "_rd"});
      e = sb.pop_front();
      chk({nm, "_ba_addr"}, 32'(s_ba), 32'(e.ba));
      bank_burst(nm, v.two, v.w0, v.w1);
      chk({nm, "_ok"}, 32'(s_ok), 32'd1);
      chk({nm, "_dout"}, s_dout, e.dout);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 22'h000004,  1'b0, 1'b0, 16'hBEEF, 16'h0000, 22'h100004, 32'h0000BEEF};
    vecs[1]  = '{0, 22'h000004,  1'b1, 1'b0, 16'h0000, 16'h0000, 22'h000000, 32'h0000BEEF};
    vecs[2]  = '{1, 22'h000010,  1'b0, 1'b1, 16'h1234, 16'h5678, 22'h000020, 32'h56781234};
    vecs[3]  = '{1, 22'h000010,  1'b1, 1'b0, 16'h0000, 16'h0000, 22'h000000, 32'h56781234};
    vecs[4]  = '{2, 22'h000006,  1'b0, 1'b0, 16'hA55A, 16'h0000, 22'h000003, 32'h0000005A};
    vecs[5]  = '{2, 22'h000007,  1'b1, 1'b0, 16'h0000, 16'h0000, 22'h000000, 32'h000000A5};
    vecs[6]  = '{0, 22'h3FFFFF,  1'b0, 1'b0, 16'h1357, 16'h0000, 22'h0FFFFF, 32'h00001357};
    vecs[7]  = '{2, 22'h3FFFFF,  1'b0, 1'b0, 16'hC3D4, 16'h0000, 22'h1FFFFF, 32'h000000C3};
    vecs[8]  = '{2, 22'h3FFFFE,  1'b1, 1'b0, 16'h0000, 16'h0000, 22'h000000, 32'h000000D4};
    vecs[9]  = '{0, 22'h000004,  1'b0, 1'b0, 16'h2468, 16'h0000, 22'h100004, 32'h00002468};
    vecs[10] = '{1, 22'h200001,  1'b0, 1'b1, 16'hAAAA, 16'hBBBB, 22'h000002, 32'hBBBBAAAA};

    reset = 1'b1;
    ack = 1'b0; dst = 1'b0; dok = 1'b0; rdy = 1'b0; rdata = 16'h0;
    cs16 = 1'b1; cs32 = 1'b0; cs8 = 1'b0;
    addr16 = 22'h0; addr32 = 22'h0; addr8 = 22'h0;
    tick();
    tick();
    chk("reset_ok", 32'(ok16), 32'd0);
    chk("reset_rd", 32'({rd16, rd32, rd8}), 32'd0);
    chk("reset_ba", 32'(ba16 | ba32 | ba8), 32'd0);
    chk("reset_dout", 32'(dout16), 32'd0);
    cs16 = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // ADDR moves mid-burst: first burst completes, no OK, then a refetch.
    do_reset();
    set_req(0, 22'h000004);
    wait_rd("chg_rd1");
    chk("chg_ba1", 32'(s_ba), 32'h100004);
    ack = 1'b1; tick(); ack = 1'b0;
    dst = 1'b1; dok = 1'b1; rdata = 16'h1111; tick();
    dst = 1'b0;
    addr16 = 22'h000008;
    rdy = 1'b1; rdata = 16'h2222; tick();
    dok = 1'b0; rdy = 1'b0;
    chk("chg_ok_low", 32'(s_ok), 32'd0);
    wait_rd("chg_rd2");
    chk("chg_ba2", 32'(s_ba), 32'h100008);
    bank_burst("chg", 1'b0, 16'h3333, 16'h0);
    chk("chg_ok", 32'(s_ok), 32'd1);
    chk("chg_dout", s_dout, 32'h3333);

    // Reset while the request is pending; late burst strobes are dropped.
    do_reset();
    set_req(0, 22'h000020);
    wait_rd("rst_rd");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_rd_low", 32'(s_rd), 32'd0);
    chk("rst_ok_low", 32'(s_ok), 32'd0);
    chk("rst_dout", s_dout, 32'd0);
    cs16 = 1'b0;
    dst = 1'b1; dok = 1'b1; rdy = 1'b1; rdata = 16'hDEAD; tick();
    dst = 1'b0; dok = 1'b0; rdy = 1'b0;
    chk("rst_late_dout", s_dout, 32'd0);
    chk("rst_late_rd", 32'(s_rd), 32'd0);
    cs16 = 1'b1;
    #1;
    chk("rst_late_ok", 32'(s_ok), 32'd0);
    wait_rd("rst_refetch_rd");
    chk("rst_refetch_ba", 32'(s_ba), 32'h100020);
    bank_burst("rst", 1'b0, 16'h4242, 16'h0);
    chk("rst_refetch_ok", 32'(s_ok), 32'd1);
    chk("rst_refetch_dout", s_dout, 32'h4242);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
